// File: rtl/bnn_layer_sequencer_pkg.sv
// Shared types and defaults for the BNN layer sequencer.
// Imported by the interface, watchdog and top level.
package bnn_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } seq_state_t;

  localparam int DEF_N_STAGES       = 3;
  localparam int DEF_TIMEOUT_CYCLES = 4096;
  localparam int DEF_CNT_W          = 16;

  function automatic int idx_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/bnn_layer_sequencer_if.sv
// Host and stage-side signal bundle of the layer sequencer.
// master = host/stages, slave = sequencer.
interface bnn_layer_sequencer_if
  import bnn_seq_pkg::*;
#(
  parameter int N_STAGES = DEF_N_STAGES,
  parameter int CNT_W    = DEF_CNT_W
) ();

  localparam int IW = idx_w(N_STAGES);

  logic                start;
  logic                ack;
  logic [N_STAGES-1:0] stage_done;
  logic [N_STAGES-1:0] stage_en;
  logic [IW-1:0]       cur_stage;
  logic                busy;
  logic                frame_done;
  logic                error;
  logic [CNT_W-1:0]    cycle_count;

  modport master (
    output start, ack, stage_done,
    input  stage_en, cur_stage, busy,
    input  frame_done, error, cycle_count
  );

  modport slave (
    input  start, ack, stage_done,
    output stage_en, cur_stage, busy,
    output frame_done, error, cycle_count
  );

endinterface

// File: rtl/bnn_layer_sequencer_watchdog.sv
// Per-stage hang detector: counts enabled cycles since the
// last clear and flags when the limit is reached.
module stage_watchdog
  import bnn_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit ARMED = (TIMEOUT_CYCLES > 0);
  localparam logic [W-1:0] LIMIT =
    ARMED ? W'(TIMEOUT_CYCLES - 1) : '0;

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Parks at LIMIT so expired stays up until cleared
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = ARMED && (cnt_q == LIMIT);

endmodule

// File: rtl/bnn_layer_sequencer.sv
// Frame controller: raises stage enables cumulatively, advances
// on done, traps hung stages and reports frame latency.
module bnn_layer_sequencer
  import bnn_seq_pkg::*;
#(
  parameter int N_STAGES       = DEF_N_STAGES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W          = DEF_CNT_W
) (
  input logic                  clk,
  input logic                  rst_n,
  bnn_layer_sequencer_if.slave seq
);

  localparam int IW = idx_w(N_STAGES);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_DONE = DONE;
  localparam logic [1:0] S_ERR  = ERR;

  localparam logic [IW-1:0]    LAST    = IW'(N_STAGES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]          state_q, state_d;
  logic [N_STAGES-1:0] en_q, en_d;
  logic [IW-1:0]       cur_q, cur_d;
  logic                busy_q, busy_d;
  logic                fdone_q, fdone_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic done_cur;
  logic wd_clear;
  logic wd_en;
  logic wd_exp;

  // Only the running stage's done level matters
  always_comb begin
    done_cur = 1'b0;
    for (int j = 0; j < N_STAGES; j++) begin
      if (cur_q == IW'(j)) begin
        done_cur = seq.stage_done[j];
      end
    end
  end

  assign wd_en    = (state_q == S_RUN);
  assign wd_clear = !wd_en || done_cur;

  stage_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wd (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (wd_clear),
    .enable (wd_en),
    .expired(wd_exp)
  );

  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    cur_d   = cur_q;
    busy_d  = busy_q;
    fdone_d = fdone_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (seq.start) begin
          state_d = S_RUN;
          en_d    = '0;
          en_d[0] = 1'b1;
          cur_d   = '0;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
        // Done beats a coinciding timeout
        if (done_cur) begin
          if (cur_q == LAST) begin
            state_d = S_DONE;
            fdone_d = 1'b1;
          end else begin
            cur_d = cur_q + 1'b1;
            en_d  = en_q | (en_q << 1);
          end
        end else if (wd_exp) begin
          state_d = S_ERR;
          en_d    = '0;
          err_d   = 1'b1;
        end
      end
      S_DONE: begin
        if (seq.ack) begin
          state_d = S_IDLE;
          en_d    = '0;
          cur_d   = '0;
          busy_d  = 1'b0;
          fdone_d = 1'b0;
        end
      end
      S_ERR: begin
        if (seq.ack) begin
          state_d = S_IDLE;
          cur_d   = '0;
          busy_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        en_d    = '0;
        cur_d   = '0;
        busy_d  = 1'b0;
        fdone_d = 1'b0;
        err_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      en_q    <= '0;
      cur_q   <= '0;
      busy_q  <= 1'b0;
      fdone_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      cur_q   <= cur_d;
      busy_q  <= busy_d;
      fdone_q <= fdone_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign seq.stage_en    = en_q;
  assign seq.cur_stage   = cur_q;
  assign seq.busy        = busy_q;
  assign seq.frame_done  = fdone_q;
  assign seq.error       = err_q;
  assign seq.cycle_count = cnt_q;

endmodule
